// File: rtl/mb_sync_rx_mc.sv
// Multi-channel toggle-request receiver: per-channel NSYNC-stage request synchronizers,
// stable-data capture and a round-robin merge onto a single valid/ready output stream.
module mb_sync_rx_mc #(
   parameter int NB    = 8,
   parameter int NCH   = 4,
   parameter int NSYNC = 2,
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              i_clock,
   input  logic              i_rst_n,
   input  logic [NCH-1:0]    i_req_tgl,
   input  logic [NCH*NB-1:0] i_data,
   output logic [NCH-1:0]    o_ack_tgl,
   output logic              o_valid,
   output logic [NB-1:0]     o_data,
   output logic [CW-1:0]     o_chan,
   input  logic              i_ready,
   output logic [NCH-1:0]    o_err
);

   logic [NCH-1:0]         sync_q [NSYNC];
   logic [NCH-1:0]         req_s;
   logic [NCH-1:0]         seen_q;
   logic [NCH-1:0]         pend_q, pend_d;
   logic [NCH-1:0][NB-1:0] hold_q, hold_d;
   logic [NCH-1:0]         ack_q, ack_d;
   logic [NCH-1:0]         err_q, err_d;
   logic [CW-1:0]          rr_q, rr_d;
   logic                   valid_q, valid_d;
   logic [NB-1:0]          data_q, data_d;
   logic [CW-1:0]          chan_q, chan_d;
   logic [NCH-1:0]         edge_w;
   logic [CW-1:0]          gnt;
   logic                   found;
   logic                   load;

   assign req_s  = sync_q[NSYNC-1];
   assign edge_w = req_s ^ seen_q;
   assign load   = (!valid_q || i_ready) && (|pend_q);

   // First pending channel at or after rr_q, wrapping modulo NCH.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && pend_q[(int'(rr_q) + i) % NCH]) begin
            found = 1'b1;
            gnt   = CW'((int'(rr_q) + i) % NCH);
         end
      end
   end

   always_comb begin
      pend_d  = pend_q;
      hold_d  = hold_q;
      ack_d   = ack_q;
      err_d   = err_q;
      rr_d    = rr_q;
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      for (int c = 0; c < NCH; c++) begin
         if (pend_q[c]) begin
            // A new request while still pending is dropped; the held word survives.
            if (edge_w[c]) err_d[c] = 1'b1;
            if (load && (gnt == CW'(c))) begin
               pend_d[c] = 1'b0;
               ack_d[c]  = ~ack_q[c];
            end
         end else if (edge_w[c]) begin
            pend_d[c] = 1'b1;
            hold_d[c] = i_data[c*NB +: NB];
         end
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = hold_q[gnt];
         chan_d  = gnt;
         rr_d    = (gnt == CW'(NCH-1)) ? '0 : gnt + 1'b1;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NSYNC; k++) sync_q[k] <= '0;
         seen_q  <= '0;
         pend_q  <= '0;
         hold_q  <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rr_q    <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else begin
         sync_q[0] <= i_req_tgl;
         for (int k = 1; k < NSYNC; k++) sync_q[k] <= sync_q[k-1];
         seen_q  <= req_s;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rr_q    <= rr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
      end
   end

   assign o_ack_tgl = ack_q;
   assign o_valid   = valid_q;
   assign o_data    = data_q;
   assign o_chan    = chan_q;
   assign o_err     = err_q;

endmodule

// File: tb/tb_mb_sync_rx_mc.sv
// Directed bench for mb_sync_rx_mc (NB=8, NCH=4, NSYNC=2); inputs change 1ns after posedge.
module tb_mb_sync_rx_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   logic [3:0]  ack, err;
   logic        valid;
   logic [7:0]  dout;
   logic [1:0]  chan;
   int          total = 0;
   int          passed = 0;

   mb_sync_rx_mc #(.NB(8), .NCH(4), .NSYNC(2)) dut (
      .i_clock(clk), .i_rst_n(rst_n), .i_req_tgl(req), .i_data(data),
      .o_ack_tgl(ack), .o_valid(valid), .o_data(dout), .o_chan(chan),
      .i_ready(ready), .o_err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; data = '0; ready = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; step(2);
      total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
      total++; if (ack !== 4'h0) $display("FAIL reset_ack: got %h want 0", ack); else passed++;
      total++; if (dout !== 8'h00) $display("FAIL reset_data: got %h want 00", dout); else passed++;
      total++; if (chan !== 2'd0) $display("FAIL reset_chan: got %0d want 0", chan); else passed++;
      total++; if (err !== 4'h0) $display("FAIL reset_err: got %h want 0", err); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      do_reset();
      ready = 1'b1; data[7:0] = 8'hA5; req[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (valid !== 1'b0) $display("FAIL lat_early_valid: edge %0d got %b want 0", i, valid); else passed++;
      end
      step();
      total++; if (valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", valid); else passed++;
      total++; if (dout !== 8'hA5) $display("FAIL lat_data: got %h want a5", dout); else passed++;
      total++; if (chan !== 2'd0) $display("FAIL lat_chan: got %0d want 0", chan); else passed++;
      total++; if (ack !== 4'b0001) $display("FAIL lat_ack: got %b want 0001", ack); else passed++;
      step();
      total++; if (valid !== 1'b0) $display("FAIL lat_valid_drop: got %b want 0", valid); else passed++;
      total++; if (ack !== 4'b0001) $display("FAIL lat_ack_hold: got %b want 0001", ack); else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      ready = 1'b1; data = 32'h13121110; req = 4'hF;
      step(3);
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if ({valid, chan, dout, ack} !== {1'b1, 2'(i), 8'(8'h10 + i), 4'((1 << (i+1)) - 1)})
            $display("FAIL b2b_word%0d: got v=%b ch=%0d d=%h ack=%b want v=1 ch=%0d d=%h ack=%b",
                     i, valid, chan, dout, ack, i, 8'(8'h10 + i), 4'((1 << (i+1)) - 1));
         else passed++;
      end
      step();
      total++; if (valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", valid); else passed++;
   endtask

   task automatic test_backpressure();
      do_reset();
      ready = 1'b0; data[15:8] = 8'h21; data[23:16] = 8'h22; req = 4'b0110;
      step(4);
      total++;
      if ({valid, chan, dout, ack} !== {1'b1, 2'd1, 8'h21, 4'b0010})
         $display("FAIL bp_first: got v=%b ch=%0d d=%h ack=%b want v=1 ch=1 d=21 ack=0010", valid, chan, dout, ack);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({valid, chan, dout, ack} !== {1'b1, 2'd1, 8'h21, 4'b0010})
            $display("FAIL bp_hold%0d: got v=%b ch=%0d d=%h ack=%b want v=1 ch=1 d=21 ack=0010", i, valid, chan, dout, ack);
         else passed++;
      end
      ready = 1'b1;
      step();
      total++;
      if ({valid, chan, dout, ack} !== {1'b1, 2'd2, 8'h22, 4'b0110})
         $display("FAIL bp_second: got v=%b ch=%0d d=%h ack=%b want v=1 ch=2 d=22 ack=0110", valid, chan, dout, ack);
      else passed++;
      step();
      total++; if (valid !== 1'b0) $display("FAIL bp_end_valid: got %b want 0", valid); else passed++;
   endtask

   task automatic test_fairness();
      int issued [2];
      int got [2];
      int words;
      int ch;
      logic [3:0] ack_prev;
      do_reset();
      ready = 1'b1;
      data[7:0] = 8'h00; data[31:24] = 8'h30;
      req[0] = ~req[0]; req[3] = ~req[3];
      issued[0] = 1; issued[1] = 1; got[0] = 0; got[1] = 0;
      words = 0; ack_prev = '0;
      for (int cyc = 0; cyc < 400 && words < 20; cyc++) begin
         step();
         if (valid === 1'b1) begin
            ch = (words % 2 == 0) ? 0 : 3;
            total++;
            if (chan !== 2'(ch)) $display("FAIL fair_chan%0d: got %0d want %0d", words, chan, ch);
            else passed++;
            total++;
            if (dout !== 8'(ch*16 + got[ch/3])) $display("FAIL fair_data%0d: got %h want %h", words, dout, 8'(ch*16 + got[ch/3]));
            else passed++;
            if (chan == 2'd0) got[0]++; else if (chan == 2'd3) got[1]++;
            words++;
         end
         for (int k = 0; k < 2; k++) begin
            ch = k * 3;
            if (ack[ch] !== ack_prev[ch] && issued[k] < 10) begin
               data[ch*8 +: 8] = 8'(ch*16 + issued[k]);
               req[ch] = ~req[ch];
               issued[k]++;
            end
         end
         ack_prev = ack;
      end
      total++; if (words != 20) $display("FAIL fair_count: got %0d words want 20", words); else passed++;
   endtask

   task automatic test_violation();
      do_reset();
      ready = 1'b0; data[7:0] = 8'h30; req[0] = 1'b1;
      step(4);
      data[15:8] = 8'h5A; req[1] = 1'b1;
      step(3);
      total++; if (err !== 4'h0) $display("FAIL viol_pre_err: got %b want 0000", err); else passed++;
      data[15:8] = 8'hFF; req[1] = 1'b0;
      step(3);
      total++; if (err !== 4'b0010) $display("FAIL viol_err: got %b want 0010", err); else passed++;
      total++;
      if ({valid, chan, dout} !== {1'b1, 2'd0, 8'h30})
         $display("FAIL viol_out_hold: got v=%b ch=%0d d=%h want v=1 ch=0 d=30", valid, chan, dout);
      else passed++;
      step(3);
      total++; if (err !== 4'b0010) $display("FAIL viol_sticky: got %b want 0010", err); else passed++;
      ready = 1'b1;
      step();
      total++;
      if ({valid, chan, dout, ack} !== {1'b1, 2'd1, 8'h5A, 4'b0011})
         $display("FAIL viol_word: got v=%b ch=%0d d=%h ack=%b want v=1 ch=1 d=5a ack=0011", valid, chan, dout, ack);
      else passed++;
      total++; if (err !== 4'b0010) $display("FAIL viol_sticky2: got %b want 0010", err); else passed++;
      ready = 1'b0; rst_n = 1'b0; req = '0;
      step();
      total++;
      if ({valid, chan, dout, ack, err} !== 19'd0)
         $display("FAIL viol_reset: got v=%b ch=%0d d=%h ack=%b err=%b want all 0", valid, chan, dout, ack, err);
      else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      ready = 1'b0; data = 32'h00424140; req = 4'b0111;
      step(4);
      total++;
      if ({valid, chan, dout} !== {1'b1, 2'd0, 8'h40})
         $display("FAIL mid_pre: got v=%b ch=%0d d=%h want v=1 ch=0 d=40", valid, chan, dout);
      else passed++;
      rst_n = 1'b0; req = '0;
      step();
      total++; if (valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", valid); else passed++;
      total++; if (ack !== 4'h0) $display("FAIL mid_ack: got %b want 0000", ack); else passed++;
      rst_n = 1'b1; ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (valid !== 1'b0) $display("FAIL mid_stale%0d: got v=%b ch=%0d d=%h want v=0", i, valid, chan, dout); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_fairness();
      test_violation();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
